jtkicker_vtimer: RTL and testbench
==================================

JTKICKER_VTIMER -- requirements
Module: jtkicker_vtimer

Interface
REQ-001 Parameter HTOTAL, default 384, pixels per line (hdump 0..HTOTAL-1).
REQ-002 Parameter VTOTAL, default 264, lines per frame (internal vcount 0..VTOTAL-1).
REQ-003 Parameter HB_START, default 256, first blanked hdump; hdump 0..HB_START-1 is active.
REQ-004 Parameter VB_START, default 240, and VB_END, default 16; lines VB_END..VB_START-1 are active.
REQ-005 Parameter HS_START, default 304, and HS_LEN, default 32; HS is high for hdump HS_START..HS_START+HS_LEN-1.
REQ-006 Parameter VS_START, default 248, and VS_LEN, default 8; VS is high for vcount VS_START..VS_START+VS_LEN-1.
REQ-007 Parameter CEN_DIV, default 8, clk cycles per pixel; 48 MHz clk gives a 6 MHz pixel rate.
REQ-008 clk  input  1  system clock, 48 MHz; the only clock; all logic is on its rising edge.
REQ-009 rst_n  input  1  reset, synchronous, active-low.
REQ-010 pxl_cen  output  1  one-clk pixel clock-enable pulse, period CEN_DIV clk cycles.
REQ-011 hdump  output  9  horizontal pixel count; hdump[8]=1 marks the blanking region at defaults.
REQ-012 vdump  output  8  vcount[7:0]; feeds the scroll and object layers.
REQ-013 LHBL  output  1  horizontal blank, active-low.
REQ-014 LVBL  output  1  vertical blank, active-low.
REQ-015 HS  output  1  horizontal sync, active-high.
REQ-016 VS  output  1  vertical sync, active-high.
REQ-017 vbl_irq  output  1  one-clk pulse at the start of vertical blank; this is the CPU interrupt request.

Function
REQ-018 A counter modulo CEN_DIV SHALL drive pxl_cen, which SHALL be high exactly one clk in every CEN_DIV clks.
REQ-019 The first pxl_cen after reset release SHALL occur on the CEN_DIV-th clk after the clk on which rst_n is sampled high.
REQ-020 hdump SHALL increment only on clks with pxl_cen high, and SHALL wrap from HTOTAL-1 to 0.
REQ-021 vcount SHALL increment on the same pxl_cen clk in which hdump wraps, and SHALL wrap from VTOTAL-1 to 0; vcount is 9 bits wide.
REQ-022 LHBL, LVBL, HS and VS SHALL be registered, SHALL update on the same pxl_cen edge as the counters, and SHALL reflect the new counter values.
REQ-023 LHBL SHALL be 1 iff hdump<HB_START.
REQ-024 LVBL SHALL be 1 iff VB_END<=vcount<VB_START.
REQ-025 vbl_irq SHALL pulse for one clk on the pxl_cen edge where vcount becomes VB_START with hdump=0; no other pulse SHALL occur in the frame.
REQ-026 Between pxl_cen pulses, every output except pxl_cen SHALL hold its value.
REQ-027 Sync window comparisons SHALL use widths wide enough that HS_START+HS_LEN and VS_START+VS_LEN do not overflow; a window that reaches TOTAL SHALL end at the wrap, not alias to the next line or frame.
REQ-028 Frame length SHALL be exactly HTOTAL*VTOTAL*CEN_DIV clks, which is 811008 at defaults.

Reset
REQ-029 While rst_n=0, all of the following SHALL be 0 at the next clk edge: the divider, hdump, vcount, pxl_cen, LHBL, LVBL, HS, VS and vbl_irq.
REQ-030 Asserting reset mid-frame SHALL abort the frame with no vbl_irq pulse; timing SHALL restart per REQ-019.

Structure
REQ-031 The default timing constants (HTOTAL, VTOTAL, blank and sync bounds, CEN_DIV) SHALL live in a shared package, jtkicker_pkg, reused by the video top-level and the testbench.
REQ-032 Sub-module jtkicker_vtimer_cen SHALL implement the CEN_DIV divider.
REQ-033 The H/V counters and decoders SHALL stay in jtkicker_vtimer.

Verification
REQ-034 Release reset, count clks: first pxl_cen on clk 8, then every 8 clks; 1000 consecutive periods checked.
REQ-035 Run one line: hdump goes 0..383 then 0; LHBL falls when hdump becomes 256 and rises when it becomes 0; HS is high for hdump 304..335.
REQ-036 Run two frames: LVBL is high for vcount 16..239; VS is high for vcount 248..255; vbl_irq pulses exactly once per frame, at vcount=240, hdump=0; frame period is 811008 clks.
REQ-037 Assert rst_n=0 at vcount=100, hdump=200 for 3 clks: all outputs are 0 on the next edge, no vbl_irq is produced, and pxl_cen resumes 8 clks after release.
REQ-038 Override HTOTAL=8 and VTOTAL=4: wrap sequences are exact, and vdump equals vcount[7:0] at every wrap.

Source files
------------

// File: rtl/jtkicker_pkg.sv
// Shared video timing constants for the Kicker board: 6 MHz pixel clock from 48 MHz,
// 384x264 raster with 256x224 visible.
package jtkicker_pkg;

    localparam int JTK_HTOTAL   = 384;
    localparam int JTK_VTOTAL   = 264;
    localparam int JTK_HB_START = 256;
    localparam int JTK_VB_START = 240;
    localparam int JTK_VB_END   = 16;
    localparam int JTK_HS_START = 304;
    localparam int JTK_HS_LEN   = 32;
    localparam int JTK_VS_START = 248;
    localparam int JTK_VS_LEN   = 8;
    localparam int JTK_CEN_DIV  = 8;

    localparam int HCNT_W = 9;
    localparam int VCNT_W = 9;

    typedef struct packed {
        int htotal;
        int vtotal;
        int hb_start;
        int vb_start;
        int vb_end;
        int hs_start;
        int hs_len;
        int vs_start;
        int vs_len;
        int cen_div;
    } vtiming_t;

    localparam vtiming_t JTK_DEFAULT_TIMING = '{
        htotal:   JTK_HTOTAL,   vtotal:   JTK_VTOTAL,
        hb_start: JTK_HB_START, vb_start: JTK_VB_START, vb_end: JTK_VB_END,
        hs_start: JTK_HS_START, hs_len:   JTK_HS_LEN,
        vs_start: JTK_VS_START, vs_len:   JTK_VS_LEN,
        cen_div:  JTK_CEN_DIV
    };

    // 32-bit arithmetic so start+len never wraps, whatever the counter width
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/jtkicker_vtimer_cen.sv
// Pixel clock-enable divider: one-clk pulse every CEN_DIV clks.
module jtkicker_vtimer_cen
    import jtkicker_pkg::*;
#(
    parameter int CEN_DIV = JTK_CEN_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic pxl_cen
);

    localparam int CW = $clog2(CEN_DIV + 1);

    // Counts 1..CEN_DIV in steady state; starting from 0 after reset puts the
    // first pulse a full CEN_DIV clks after the release edge.
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            pxl_cen <= 1'b0;
        end else begin
            if (cnt == CW'(CEN_DIV))
                cnt <= CW'(1);
            else
                cnt <= cnt + CW'(1);
            pxl_cen <= (cnt == CW'(CEN_DIV));
        end
    end

endmodule

// File: rtl/jtkicker_vtimer.sv
// Video timing generator: pixel/line counters with registered blank, sync and
// vertical-blank interrupt, all advancing on the pixel clock-enable.
module jtkicker_vtimer
    import jtkicker_pkg::*;
#(
    parameter int HTOTAL   = JTK_HTOTAL,
    parameter int VTOTAL   = JTK_VTOTAL,
    parameter int HB_START = JTK_HB_START,
    parameter int VB_START = JTK_VB_START,
    parameter int VB_END   = JTK_VB_END,
    parameter int HS_START = JTK_HS_START,
    parameter int HS_LEN   = JTK_HS_LEN,
    parameter int VS_START = JTK_VS_START,
    parameter int VS_LEN   = JTK_VS_LEN,
    parameter int CEN_DIV  = JTK_CEN_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              pxl_cen,
    output logic [HCNT_W-1:0] hdump,
    output logic [7:0]        vdump,
    output logic              LHBL,
    output logic              LVBL,
    output logic              HS,
    output logic              VS,
    output logic              vbl_irq
);

    logic [VCNT_W-1:0] vcount;
    logic [HCNT_W-1:0] h_nxt;
    logic [VCNT_W-1:0] v_nxt;

    jtkicker_vtimer_cen #(
        .CEN_DIV (CEN_DIV)
    ) u_cen (
        .clk     (clk),
        .rst_n   (rst_n),
        .pxl_cen (pxl_cen)
    );

    always_comb begin
        h_nxt = hdump;
        v_nxt = vcount;
        if (pxl_cen) begin
            if (hdump == HCNT_W'(HTOTAL - 1)) begin
                h_nxt = '0;
                v_nxt = (vcount == VCNT_W'(VTOTAL - 1)) ? '0 : vcount + VCNT_W'(1);
            end else begin
                h_nxt = hdump + HCNT_W'(1);
            end
        end
    end

    // Decoders look at the next counter values so flags and counters change together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdump   <= '0;
            vcount  <= '0;
            LHBL    <= 1'b0;
            LVBL    <= 1'b0;
            HS      <= 1'b0;
            VS      <= 1'b0;
            vbl_irq <= 1'b0;
        end else begin
            vbl_irq <= 1'b0;
            if (pxl_cen) begin
                hdump   <= h_nxt;
                vcount  <= v_nxt;
                LHBL    <= int'(h_nxt) < HB_START;
                LVBL    <= (int'(v_nxt) >= VB_END) && (int'(v_nxt) < VB_START);
                HS      <= in_window(int'(h_nxt), HS_START, HS_LEN);
                VS      <= in_window(int'(v_nxt), VS_START, VS_LEN);
                vbl_irq <= (int'(v_nxt) == VB_START) && (h_nxt == '0);
            end
        end
    end

    assign vdump = vcount[7:0];

endmodule

// File: tb/tb_jtkicker_vtimer.sv
// Bench for jtkicker_vtimer: three instances (defaults, fast-pixel, tiny raster)
// compared every clk against a closed-form model of the raster position.
module tb_jtkicker_vtimer;
    import jtkicker_pkg::*;

    localparam vtiming_t CFG_A = JTK_DEFAULT_TIMING;
    localparam vtiming_t CFG_B = '{htotal: 64, vtotal: 264, hb_start: 48, vb_start: 240, vb_end: 16,
                                   hs_start: 56, hs_len: 8, vs_start: 248, vs_len: 8, cen_div: 1};
    localparam vtiming_t CFG_C = '{htotal: 8, vtotal: 4, hb_start: 6, vb_start: 3, vb_end: 1,
                                   hs_start: 5, hs_len: 3, vs_start: 2, vs_len: 2, cen_div: 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs m clks after the release edge (m=-1: reset state).
    // Position is simply the number of pixel steps taken so far.
    function automatic logic [22:0] exp_out(input vtiming_t t, input int m);
        int  d, n, hd, vc;
        logic pxl, lhbl, lvbl, hs, vs, irq;
        d   = t.cen_div;
        n   = (m >= d + 1) ? (m - 1) / d : 0;
        pxl = (m >= d) && (m % d == 0);
        if (n == 0) return {pxl, 22'b0};
        hd   = n % t.htotal;
        vc   = (n / t.htotal) % t.vtotal;
        lhbl = hd < t.hb_start;
        lvbl = (vc >= t.vb_end) && (vc < t.vb_start);
        hs   = (hd >= t.hs_start) && (hd < t.hs_start + t.hs_len);
        vs   = (vc >= t.vs_start) && (vc < t.vs_start + t.vs_len);
        irq  = ((m - 1) % d == 0) && (vc == t.vb_start) && (hd == 0);
        return {pxl, 9'(hd), 8'(vc), lhbl, lvbl, hs, vs, irq};
    endfunction

    logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic       a_pxl, b_pxl, c_pxl;
    logic [8:0] a_hd, b_hd, c_hd;
    logic [7:0] a_vd, b_vd, c_vd;
    logic       a_lhbl, a_lvbl, a_hs, a_vs, a_irq;
    logic       b_lhbl, b_lvbl, b_hs, b_vs, b_irq;
    logic       c_lhbl, c_lvbl, c_hs, c_vs, c_irq;

    jtkicker_vtimer u_a (
        .clk(clk), .rst_n(rst_a), .pxl_cen(a_pxl), .hdump(a_hd), .vdump(a_vd),
        .LHBL(a_lhbl), .LVBL(a_lvbl), .HS(a_hs), .VS(a_vs), .vbl_irq(a_irq)
    );

    jtkicker_vtimer #(
        .HTOTAL(CFG_B.htotal), .VTOTAL(CFG_B.vtotal), .HB_START(CFG_B.hb_start),
        .VB_START(CFG_B.vb_start), .VB_END(CFG_B.vb_end), .HS_START(CFG_B.hs_start),
        .HS_LEN(CFG_B.hs_len), .VS_START(CFG_B.vs_start), .VS_LEN(CFG_B.vs_len),
        .CEN_DIV(CFG_B.cen_div)
    ) u_b (
        .clk(clk), .rst_n(rst_b), .pxl_cen(b_pxl), .hdump(b_hd), .vdump(b_vd),
        .LHBL(b_lhbl), .LVBL(b_lvbl), .HS(b_hs), .VS(b_vs), .vbl_irq(b_irq)
    );

    jtkicker_vtimer #(
        .HTOTAL(CFG_C.htotal), .VTOTAL(CFG_C.vtotal), .HB_START(CFG_C.hb_start),
        .VB_START(CFG_C.vb_start), .VB_END(CFG_C.vb_end), .HS_START(CFG_C.hs_start),
        .HS_LEN(CFG_C.hs_len), .VS_START(CFG_C.vs_start), .VS_LEN(CFG_C.vs_len),
        .CEN_DIV(CFG_C.cen_div)
    ) u_c (
        .clk(clk), .rst_n(rst_c), .pxl_cen(c_pxl), .hdump(c_hd), .vdump(c_vd),
        .LHBL(c_lhbl), .LVBL(c_lvbl), .HS(c_hs), .VS(c_vs), .vbl_irq(c_irq)
    );

    logic [22:0] out_a, out_b, out_c;
    assign out_a = {a_pxl, a_hd, a_vd, a_lhbl, a_lvbl, a_hs, a_vs, a_irq};
    assign out_b = {b_pxl, b_hd, b_vd, b_lhbl, b_lvbl, b_hs, b_vs, b_irq};
    assign out_c = {c_pxl, c_hd, c_vd, c_lhbl, c_lvbl, c_hs, c_vs, c_irq};

    // clks since the last reset edge (0 = in reset, -1 = not yet reset)
    int k_a = -1, k_b = -1, k_c = -1;
    always @(posedge clk) begin
        k_a <= !rst_a ? 0 : (k_a >= 0 ? k_a + 1 : k_a);
        k_b <= !rst_b ? 0 : (k_b >= 0 ? k_b + 1 : k_b);
        k_c <= !rst_c ? 0 : (k_c >= 0 ? k_c + 1 : k_c);
    end

    always @(negedge clk) begin
        if (k_a >= 0) check_eq("outs_a", 32'(out_a), 32'(exp_out(CFG_A, k_a - 1)));
        if (k_b >= 0) check_eq("outs_b", 32'(out_b), 32'(exp_out(CFG_B, k_b - 1)));
        if (k_c >= 0) check_eq("outs_c", 32'(out_c), 32'(exp_out(CFG_C, k_c - 1)));
    end

    // Expects rst_a to have just been released on a falling edge
    task automatic a_first_cen(input string tag);
        int c;
        @(posedge clk);
        c = 0;
        do begin
            @(posedge clk);
            c++;
            #1;
        end while (!a_pxl && c < 40);
        check_eq(tag, c, CFG_A.cen_div);
    endtask

    task automatic wait_a_hd(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (a_hd == 9'(target)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_a;
        bit ok;
        int c;
        logic [7:0] vd0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        a_first_cen("a_first_cen");
        for (int p = 0; p < 1000; p++) begin
            c = 0;
            do begin
                @(posedge clk);
                c++;
                #1;
            end while (!a_pxl && c < 40);
            check_eq("a_cen_period", c, CFG_A.cen_div);
        end
        wait_a_hd(0, ok);   check_eq("a_reach_h0", ok, 1);
        vd0 = a_vd;
        wait_a_hd(255, ok); check_eq("a_lhbl_255", a_lhbl, 1);
        wait_a_hd(256, ok); check_eq("a_lhbl_256", a_lhbl, 0);
        check_eq("a_hs_256", a_hs, 0);
        wait_a_hd(303, ok); check_eq("a_hs_303", a_hs, 0);
        wait_a_hd(304, ok); check_eq("a_hs_304", a_hs, 1);
        wait_a_hd(335, ok); check_eq("a_hs_335", a_hs, 1);
        wait_a_hd(336, ok); check_eq("a_hs_336", a_hs, 0);
        wait_a_hd(383, ok); check_eq("a_reach_h383", ok, 1);
        wait_a_hd(0, ok);
        check_eq("a_lhbl_wrap", a_lhbl, 1);
        check_eq("a_vd_step", a_vd, 8'(vd0 + 8'd1));
        repeat (3) begin
            repeat ($urandom_range(50, 3000)) @(negedge clk);
            rst_a = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            rst_a = 1'b1;
            a_first_cen("a_cen_after_rst");
        end
        repeat (500) @(negedge clk);
    endtask

    task automatic run_b;
        bit found;
        int c, irqs;
        localparam int FRAME = CFG_B.htotal * CFG_B.vtotal * CFG_B.cen_div;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (b_irq) begin found = 1'b1; break; end
        end
        check_eq("b_irq1_seen", found, 1);
        check_eq("b_irq1_vd", b_vd, CFG_B.vb_start);
        check_eq("b_irq1_hd", b_hd, 0);
        check_eq("b_irq1_lvbl", b_lvbl, 0);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!b_irq && c < FRAME + 100);
        check_eq("b_frame_period", c, FRAME);
        check_eq("b_irq2_vd", b_vd, CFG_B.vb_start);
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (b_vd == 8'd100 && b_hd == 9'd40) begin found = 1'b1; break; end
        end
        check_eq("b_reach_v100", found, 1);
        irqs = 0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check_eq("b_rst_outs", 32'(out_b), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (b_irq) irqs++;
        end
        rst_b = 1'b1;
        @(posedge clk);
        c = 0;
        do begin
            @(posedge clk);
            c++;
            #1;
        end while (!b_pxl && c < 40);
        check_eq("b_cen_resume", c, CFG_B.cen_div);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (b_irq) irqs++;
        end
        check_eq("b_no_irq_after_abort", irqs, 0);
    endtask

    task automatic run_c;
        int v_exp;
        logic [8:0] prev_hd;
        for (int it = 0; it < 30; it++) begin
            rst_c = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rst_c = 1'b1;
            v_exp   = 0;
            prev_hd = '0;
            repeat ($urandom_range(20, 600)) begin
                @(negedge clk);
                if (c_hd != prev_hd) begin
                    check_eq("c_hstep", c_hd, (prev_hd + 1) % CFG_C.htotal);
                    if (c_hd == 9'd0) begin
                        v_exp = (v_exp + 1) % CFG_C.vtotal;
                        check_eq("c_wrap_vdump", c_vd, v_exp);
                    end
                end
                prev_hd = c_hd;
            end
        end
    endtask

    initial begin
        fork
            run_a();
            run_b();
            run_c();
        join
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
